bank_write_ctrl: RTL and testbench

BANK_WRITE_CTRL -- requirements
Module: bank_write_ctrl

---
 rtl/bank_write_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_bank_write_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bank_write_ctrl.sv
// bank_write_ctrl
//   Writes channel samples into a two-bank sample memory while an
//   acoustic-emission (AE) event is active. Each accepted sample produces a
//   registered write one cycle later. When a bank fills up, the controller
//   moves to the other bank and keeps recording. An acquisition ends after
//   END_HOLD consecutive cycles with ae_active low. The index reached in the
//   last, partial bank is then reported and a completion pulse is issued.
//
//   Optional feature (macro BANK_WR_MAX_LEN_EN): an acquisition is limited to
//   MAX_BANKS full banks. When the limit is reached the acquisition ends and
//   the sticky flag 'truncated' is set.
//
// Ports
//   clk                     rising-edge clock
//   reset                   asynchronous, active-high reset
//   ae_active               AE detector level
//   sample_valid            one-cycle strobe qualifying sample_data
//   sample_data [DW-1:0]    channel sample
//   we                      registered memory write enable
//   wr_addr [8:0]           {bank, word index}, registered
//   wr_data [DW-1:0]        registered sample
//   bank0_full, bank1_full  one-cycle pulse issued with the last write of a bank
//   memorization_completed  one-cycle pulse, acquisition ended
//   idx_final [7:0]         word count of the last, partial bank
//   truncated               sticky, acquisition cut by the bank limit
//   dbg_state [1:0]         current FSM state, for observation only
//
// Handshake: sample_valid has no back-pressure. When sample_valid is high in
//   IDLE (with ae_active high), in ACQ or in TAIL, the sample is written.
//   When sample_valid is high in DONE, or in IDLE with ae_active low, the
//   sample is dropped.
module bank_write_ctrl #(
  parameter int DW         = 16,
  parameter int BANK_DEPTH = 200,
  parameter int END_HOLD   = 4,
  parameter int MAX_BANKS  = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ae_active,
  input  logic          sample_valid,
  input  logic [DW-1:0] sample_data,
  output logic          we,
  output logic [8:0]    wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          bank0_full,
  output logic          bank1_full,
  output logic          memorization_completed,
  output logic [7:0]    idx_final,
  output logic          truncated,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACQ  = 2'd1,
    S_TAIL = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(BANK_DEPTH - 1);
  localparam logic [7:0] HOLD_END = 8'(END_HOLD);

  state_t        state_q, state_d;
  logic          bank_q, bank_d;
  logic [7:0]    wr_idx_q, wr_idx_d;
  logic [7:0]    hold_q, hold_d;
  logic [7:0]    idx_final_q, idx_final_d;
  logic          we_q, we_d;
  logic [8:0]    wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic          full0_q, full0_d;
  logic          full1_q, full1_d;
  logic          done_q, done_d;
  logic          accept;
  logic          at_last;

`ifdef BANK_WR_MAX_LEN_EN
  localparam logic [15:0] MAX_CNT = 16'(MAX_BANKS);
  logic [15:0] bank_cnt_q, bank_cnt_d;
  logic        trunc_q, trunc_d;
  logic        limit_hit;
`endif

  assign at_last = (wr_idx_q == LAST_IDX);

  always_comb begin
    state_d     = state_q;
    bank_d      = bank_q;
    wr_idx_d    = wr_idx_q;
    hold_d      = hold_q;
    idx_final_d = idx_final_q;
    we_d        = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    full0_d     = 1'b0;
    full1_d     = 1'b0;
    done_d      = 1'b0;
    accept      = 1'b0;
`ifdef BANK_WR_MAX_LEN_EN
    bank_cnt_d  = bank_cnt_q;
    trunc_d     = trunc_q;
    limit_hit   = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (ae_active) begin
          state_d = S_ACQ;
          hold_d  = 8'd0;
          accept  = sample_valid;
`ifdef BANK_WR_MAX_LEN_EN
          bank_cnt_d = 16'd0;
          trunc_d    = 1'b0;
`endif
        end
      end
      S_ACQ: begin
        accept = sample_valid;
        if (!ae_active) begin
          // With a one-cycle hold, the first low cycle already ends the
          // acquisition.
          if (HOLD_END == 8'd1) begin
            state_d = S_DONE;
          end else begin
            state_d = S_TAIL;
            hold_d  = 8'd1;
          end
        end
      end
      S_TAIL: begin
        accept = sample_valid;
        if (ae_active) begin
          state_d = S_ACQ;
          hold_d  = 8'd0;
        end else begin
          hold_d = hold_q + 8'd1;
          if (hold_d == HOLD_END) state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d   = 1'b1;
        bank_d   = ~bank_q;
        wr_idx_d = 8'd0;
        hold_d   = 8'd0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Write path. This is shared by the IDLE start cycle, ACQ and TAIL.
    if (accept) begin
      we_d      = 1'b1;
      wr_addr_d = {bank_q, wr_idx_q};
      wr_data_d = sample_data;
      if (at_last) begin
        full0_d  = ~bank_q;
        full1_d  = bank_q;
        wr_idx_d = 8'd0;
        bank_d   = ~bank_q;
      end else begin
        wr_idx_d = wr_idx_q + 8'd1;
      end
    end

`ifdef BANK_WR_MAX_LEN_EN
    if (accept && at_last) begin
      bank_cnt_d = bank_cnt_d + 16'd1;
      limit_hit  = (bank_cnt_d == MAX_CNT);
    end
    // The bank limit ends the acquisition regardless of ae_active.
    if (limit_hit) begin
      state_d = S_DONE;
      trunc_d = 1'b1;
    end
`endif

    // idx_final takes the post-write index. A full write on the same edge
    // as the transition therefore reports 0.
    if ((state_d == S_DONE) && (state_q != S_DONE)) idx_final_d = wr_idx_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      bank_q      <= 1'b0;
      wr_idx_q    <= 8'd0;
      hold_q      <= 8'd0;
      idx_final_q <= 8'd0;
      we_q        <= 1'b0;
      wr_addr_q   <= 9'd0;
      wr_data_q   <= '0;
      full0_q     <= 1'b0;
      full1_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      wr_idx_q    <= wr_idx_d;
      hold_q      <= hold_d;
      idx_final_q <= idx_final_d;
      we_q        <= we_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      full0_q     <= full0_d;
      full1_q     <= full1_d;
      done_q      <= done_d;
    end
  end

`ifdef BANK_WR_MAX_LEN_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank_cnt_q <= 16'd0;
      trunc_q    <= 1'b0;
    end else begin
      bank_cnt_q <= bank_cnt_d;
      trunc_q    <= trunc_d;
    end
  end
  assign truncated = trunc_q;
`else
  // Acquisitions are unlimited in this build. For any legal MAX_BANKS this
  // comparison is constant 0.
  assign truncated = (MAX_BANKS < 0);
`endif

  assign we                     = we_q;
  assign wr_addr                = wr_addr_q;
  assign wr_data                = wr_data_q;
  assign bank0_full             = full0_q;
  assign bank1_full             = full1_q;
  assign memorization_completed = done_q;
  assign idx_final              = idx_final_q;
  assign dbg_state              = state_q;

endmodule

// File: tb/tb_bank_write_ctrl.sv
module tb_bank_write_ctrl;
  localparam int DW         = 16;
  localparam int BANK_DEPTH = 200;
  localparam int END_HOLD   = 4;
  localparam int MAX_BANKS  = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          ae_active = 1'b0;
  logic          sample_valid = 1'b0;
  logic [DW-1:0] sample_data = '0;
  logic          we;
  logic [8:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic          bank0_full, bank1_full, memorization_completed, truncated;
  logic [7:0]    idx_final;
  logic [1:0]    dbg_state;

  bank_write_ctrl #(
    .DW(DW), .BANK_DEPTH(BANK_DEPTH), .END_HOLD(END_HOLD), .MAX_BANKS(MAX_BANKS)
  ) dut (
    .clk(clk), .reset(reset), .ae_active(ae_active),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .bank0_full(bank0_full), .bank1_full(bank1_full),
    .memorization_completed(memorization_completed),
    .idx_final(idx_final), .truncated(truncated), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s (cycle %0d): got %0h, required %0h", name, cyc, act, exp);
  endtask

  function automatic logic [63:0] dut_vec();
    return {26'd0, we, wr_addr, wr_data, bank0_full, bank1_full,
            memorization_completed, idx_final, truncated};
  endfunction

  // Transaction-level model: acquisition in progress or not, a run length
  // of low ae_active cycles, and a bank/index pointer.
  bit         m_busy, m_end, m_bank, m_trunc, fin;
  int         m_low, m_idx, m_fulls, m_idx_final;
  logic       e_we, e_f0, e_f1, e_done;
  logic [8:0] e_addr;
  logic [DW-1:0] e_data;

  // Events observed on the DUT, used by the hand-computed checks.
  int         done_cnt = 0, done_cyc = -1, f0_cyc = -1, f1_cyc = -1;
  logic [8:0] f0_addr = '0, f1_addr = '0, first_addr = '0;
  bit         first_armed = 0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_busy = 0; m_end = 0; m_bank = 0; m_trunc = 0;
      m_low = 0; m_idx = 0; m_fulls = 0; m_idx_final = 0;
      e_we = 0; e_f0 = 0; e_f1 = 0; e_done = 0; e_addr = '0; e_data = '0;
    end else begin
      e_we = 0; e_f0 = 0; e_f1 = 0;
      e_done = m_end;
      if (m_end) begin
        m_end = 0; m_bank = ~m_bank; m_idx = 0;
      end else if (m_busy || ae_active) begin
        if (!m_busy) begin
          m_busy = 1; m_low = 0; m_trunc = 0; m_fulls = 0;
        end
        fin = 0;
        if (sample_valid) begin
          e_we = 1; e_addr = {m_bank, m_idx[7:0]}; e_data = sample_data;
          if (m_idx == BANK_DEPTH - 1) begin
            if (m_bank) e_f1 = 1; else e_f0 = 1;
            m_bank = ~m_bank; m_idx = 0; m_fulls++;
`ifdef BANK_WR_MAX_LEN_EN
            if (m_fulls == MAX_BANKS) begin fin = 1; m_trunc = 1; end
`endif
          end else begin
            m_idx++;
          end
        end
        if (!fin) begin
          m_low = ae_active ? 0 : m_low + 1;
          if (m_low >= END_HOLD) fin = 1;
        end
        if (fin) begin
          m_busy = 0; m_end = 1; m_idx_final = m_idx;
        end
      end
    end
    #1;
    check("outputs", dut_vec(),
          {26'd0, e_we, e_addr, e_data, e_f0, e_f1, e_done, m_idx_final[7:0], m_trunc});
    if (memorization_completed) begin done_cnt++; done_cyc = cyc; end
    if (bank0_full) begin f0_cyc = cyc; f0_addr = wr_addr; end
    if (bank1_full) begin f1_cyc = cyc; f1_addr = wr_addr; end
    if (first_armed && we) begin first_addr = wr_addr; first_armed = 0; end
  end

  task automatic drive(input bit ae, input bit sv, input int data);
    @(negedge clk);
    ae_active = ae; sample_valid = sv; sample_data = DW'(data);
  endtask

  task automatic run_samples(input int n, input bit ae, input int base);
    for (int i = 0; i < n; i++) drive(ae, 1'b1, base + i);
  endtask

  task automatic wait_done(input int start_cnt, input int budget);
    int k = 0;
    while (done_cnt == start_cnt && k < budget) begin
      drive(1'b0, 1'b0, 0);
      k++;
    end
    check("done_timeout", 64'(done_cnt > start_cnt), 64'd1);
    drive(1'b0, 1'b0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; ae_active = 0; sample_valid = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  int d0, last_high;

  initial begin
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", dut_vec(), 64'd0);
    reset = 1'b0;

    // 50 samples in bank 0
    first_armed = 1; d0 = done_cnt;
    run_samples(50, 1'b1, 16'h1000);
    drive(1'b0, 1'b0, 0);
    last_high = cyc;
    wait_done(d0, 20);
    check("s1_first_addr", 64'(first_addr), 64'd0);
    check("s1_idx_final", 64'(idx_final), 64'd50);
    check("s1_done_latency", 64'(done_cyc - last_high), 64'd5);

    // The following acquisition goes to bank 1
    first_armed = 1; d0 = done_cnt;
    run_samples(10, 1'b1, 16'h2000);
    wait_done(d0, 20);
    check("s1b_first_addr", 64'(first_addr), 64'h100);

    // 450 samples span two full banks
    d0 = done_cnt;
    run_samples(450, 1'b1, 16'h3000);
    wait_done(d0, 20);
    check("s2_f0_addr", 64'(f0_addr), 64'd199);
    check("s2_f1_addr", 64'(f1_addr), 64'd455);
    check("s2_idx_final", 64'(idx_final), 64'd50);
    first_armed = 1; d0 = done_cnt;
    run_samples(5, 1'b1, 16'h4000);
    wait_done(d0, 20);
    check("s2_next_addr", 64'(first_addr), 64'h100);

    // A 3-cycle low glitch does not end the acquisition
    d0 = done_cnt;
    run_samples(20, 1'b1, 16'h5000);
    run_samples(3, 1'b0, 16'h5100);
    run_samples(20, 1'b1, 16'h5200);
    check("s3_no_done", 64'(done_cnt), 64'(d0));
    wait_done(d0, 20);
    check("s3_idx_final", 64'(idx_final), 64'd43);

    // The 200th sample lands on the last hold cycle
    do_reset();
    run_samples(196, 1'b1, 16'h6000);
    d0 = done_cnt;
    run_samples(4, 1'b0, 16'h6100);
    wait_done(d0, 20);
    check("s4_f0_addr", 64'(f0_addr), 64'd199);
    check("s4_full_then_done", 64'(done_cyc - f0_cyc), 64'd1);
    check("s4_idx_final", 64'(idx_final), 64'd0);

    // Reset aborts a running acquisition
    d0 = done_cnt;
    run_samples(120, 1'b1, 16'h7000);
    @(posedge clk);
    #3;
    check("s5_we_before_reset", 64'(we), 64'd1);
    reset = 1'b1;
    #1;
    check("s5_async_reset", dut_vec(), 64'd0);
    @(negedge clk);
    ae_active = 0; sample_valid = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) drive(1'b0, 1'b0, 0);
    check("s5_no_done_on_abort", 64'(done_cnt), 64'(d0));
    first_armed = 1;
    run_samples(10, 1'b1, 16'h7100);
    wait_done(d0, 20);
    check("s5_restart_addr", 64'(first_addr), 64'd0);

`ifdef BANK_WR_MAX_LEN_EN
    // The bank limit ends the acquisition while ae_active is still high
    do_reset();
    d0 = done_cnt;
    run_samples(BANK_DEPTH * MAX_BANKS, 1'b1, 16'h8000);
    wait_done(d0, 10);
    check("s6_truncated", 64'(truncated), 64'd1);
    check("s6_idx_final", 64'(idx_final), 64'd0);
    drive(1'b1, 1'b0, 0);
    drive(1'b0, 1'b0, 0);
    check("s6_trunc_cleared", 64'(truncated), 64'd0);
`else
    check("truncated_tied_low", 64'(truncated), 64'd0);
`endif

    repeat (3) drive(1'b0, 1'b0, 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
